// File: rtl/metro_rx_credit_buffer_if.sv
// Link/NoC signal bundle for the Metro-MPI receive credit buffer.
// Signal suffixes are from the buffer's point of view; the buffer uses the slave modport.
interface metro_rx_credit_buffer_if #(
    parameter int DATA_WIDTH   = 64,
    parameter int CREDIT_WIDTH = 3
);
    logic                    link_valid_i;
    logic [DATA_WIDTH-1:0]   link_data_i;
    logic                    link_yummy_o;
    logic                    noc_valid_o;
    logic [DATA_WIDTH-1:0]   noc_data_o;
    logic                    noc_ready_i;
    logic [CREDIT_WIDTH-1:0] occupancy_o;
    logic                    overflow_o;

    modport slave (
        input  link_valid_i, link_data_i, noc_ready_i,
        output link_yummy_o, noc_valid_o, noc_data_o, occupancy_o, overflow_o
    );

    modport master (
        output link_valid_i, link_data_i, noc_ready_i,
        input  link_yummy_o, noc_valid_o, noc_data_o, occupancy_o, overflow_o
    );
endinterface

// File: rtl/metro_rx_credit_buffer.sv
// Receive endpoint of the Metro-MPI credit link: DEPTH-entry flit FIFO toward the NoC,
// returning one registered yummy pulse for every flit the NoC consumes.
module metro_rx_credit_buffer #(
    parameter int DATA_WIDTH   = 64,
    parameter int CREDIT_WIDTH = 3,
    parameter int DEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    metro_rx_credit_buffer_if.slave  bus
);
    localparam int                      PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]        LAST_PTR   = PTR_W'(DEPTH - 1);
    localparam logic [CREDIT_WIDTH-1:0] FULL_COUNT = CREDIT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CREDIT_WIDTH-1:0] count_q, count_d;
    logic                    yummy_q, yummy_d;
    logic                    overflow_q, overflow_d;
    logic                    deq;
    logic                    enq;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path infers a latch.
        deq        = (count_q != '0) && bus.noc_ready_i;
        // A full FIFO still accepts when the head leaves in the same cycle.
        enq        = bus.link_valid_i && ((count_q != FULL_COUNT) || deq);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        yummy_d    = deq;
        overflow_d = overflow_q | (bus.link_valid_i && !enq);

        if (enq) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (deq) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;

        if (enq && !deq)      count_d = count_q + 1'b1;
        else if (deq && !enq) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: storage is reset too, so the fall-through data output is never X after reset.
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            yummy_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (enq) mem_q[wr_ptr_q] <= bus.link_data_i;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            yummy_q    <= yummy_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.noc_valid_o  = (count_q != '0);
    assign bus.noc_data_o   = mem_q[rd_ptr_q];
    assign bus.occupancy_o  = count_q;
    assign bus.link_yummy_o = yummy_q;
    assign bus.overflow_o   = overflow_q;
endmodule
